// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Sequences the PLL in the 50 MHz reference domain. It pulses the PLL reset
//   and waits for lock, retrying on timeout. Lock must then hold stable before
//   the system reset is released. A filtered lock loss, or a soft request,
//   restarts the whole sequence.
// Ports:
//   clkin      50 MHz reference clock (same net as the PLL clkin)
//   reset      asynchronous active-high reset
//   pll_lock   PLL lock, asynchronous to clkin
//   soft_rst   one-cycle request to re-run the sequence (ignored in PLL_RST)
//   pll_reset  PLL reset, active-high, high only in PLL_RST
//   sys_rst    system reset, active-high, low only in RUN
//   ready      high in RUN
//   retry_cnt  saturating count of lock-timeout retries
//   loss_cnt   saturating count of lock losses detected in RUN
//   state_o    PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOSS_FILTER   = 4,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       soft_rst,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_sync1;
  logic             r_lock_s;
  logic             r_pll_reset;
  logic             r_sys_rst;
  logic             r_ready;
  logic [7:0]       r_retry;
  logic [7:0]       r_loss;

  state_t           w_next;
  logic [CNT_W-1:0] w_timer_nxt;
  logic             w_retry_inc;
  logic             w_loss_inc;

  // Two-flop synchroniser for the asynchronous lock; only r_lock_s is used.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_timer_nxt = r_timer + CNT_W'(1);
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_timer == RST_LAST) begin
          w_next      = WAIT_LOCK;
          w_timer_nxt = '0;
        end
      end
      WAIT_LOCK: begin
        if (soft_rst) begin
          w_next      = PLL_RST;
          w_timer_nxt = '0;
        end else if (r_lock_s) begin
          w_next      = STABLE;
          w_timer_nxt = '0;
        end else if (r_timer == TIMEOUT_LAST) begin
          w_next      = PLL_RST;
          w_timer_nxt = '0;
          w_retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (soft_rst) begin
          w_next      = PLL_RST;
          w_timer_nxt = '0;
        end else if (!r_lock_s) begin
          w_next      = WAIT_LOCK;
          w_timer_nxt = '0;
        end else if (r_timer == STABLE_LAST) begin
          // Timer restarts so RUN begins with a clean loss filter.
          w_next      = RUN;
          w_timer_nxt = '0;
        end
      end
      RUN: begin
        // In RUN the timer counts consecutive lock-low cycles.
        if (soft_rst) begin
          w_next      = PLL_RST;
          w_timer_nxt = '0;
        end else if (r_lock_s) begin
          w_timer_nxt = '0;
        end else if (r_timer == LOSS_LAST) begin
          w_next      = PLL_RST;
          w_timer_nxt = '0;
          w_loss_inc  = 1'b1;
        end
      end
      default: begin
        w_next      = PLL_RST;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register, with no input-to-output combinational path.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state     <= PLL_RST;
      r_timer     <= '0;
      r_pll_reset <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_retry     <= '0;
      r_loss      <= '0;
    end else begin
      r_state     <= w_next;
      r_timer     <= w_timer_nxt;
      r_pll_reset <= (w_next == PLL_RST);
      r_sys_rst   <= (w_next != RUN);
      r_ready     <= (w_next == RUN);
      if (w_retry_inc && (r_retry != 8'hFF)) r_retry <= r_retry + 8'd1;
      if (w_loss_inc && (r_loss != 8'hFF))   r_loss  <= r_loss + 8'd1;
    end
  end

  assign pll_reset = r_pll_reset;
  assign sys_rst   = r_sys_rst;
  assign ready     = r_ready;
  assign retry_cnt = r_retry;
  assign loss_cnt  = r_loss;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with small timing parameters
//   (RST=4, TIMEOUT=20, STABLE=8, LOSS=3). Inputs change and outputs are
//   sampled 1 ns after each rising edge.
module tb_pll_reset_sequencer;

  logic       clkin;
  logic       reset;
  logic       pll_lock;
  logic       soft_rst;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [1:0] state_o;

  int n_tot;
  int n_bad;

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .LOSS_FILTER  (3),
    .CNT_W        (8)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .pll_lock (pll_lock),
    .soft_rst (soft_rst),
    .pll_reset(pll_reset),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt),
    .state_o  (state_o)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  initial begin
    n_tot    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    pll_lock = 1'b0;
    soft_rst = 1'b0;

    // Reset values
    tick(2);
    chk("rst_state", state_o, 0);
    chk("rst_pllrst", pll_reset, 1);
    chk("rst_sysrst", sys_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_loss", loss_cnt, 0);

    // 1. Nominal bring-up (edge numbers counted from reset release)
    reset = 1'b0;
    tick(3);  chk("t1_pllrst_e3", pll_reset, 1); chk("t1_state_e3", state_o, 0);
    tick(1);  chk("t1_pllrst_e4", pll_reset, 0); chk("t1_state_e4", state_o, 1);
    tick(9);  pll_lock = 1'b1;                     // lock sampled at edge 14
    tick(2);  chk("t1_state_e15", state_o, 1);
    tick(1);  chk("t1_state_e16", state_o, 2);
    tick(7);  chk("t1_state_e23", state_o, 2); chk("t1_sysrst_e23", sys_rst, 1);
    tick(1);  chk("t1_state_e24", state_o, 3); chk("t1_sysrst_e24", sys_rst, 0);
    chk("t1_ready", ready, 1); chk("t1_retry", retry_cnt, 0);

    // 2. Timeout retries: three 24-cycle sequences without lock
    reset = 1'b1; pll_lock = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(23); chk("t2_state_e23", state_o, 1); chk("t2_retry_e23", retry_cnt, 0);
    tick(1);  chk("t2_state_e24", state_o, 0); chk("t2_pllrst_e24", pll_reset, 1);
    chk("t2_retry_e24", retry_cnt, 1);
    tick(3);  chk("t2_pllrst_e27", pll_reset, 1);
    tick(1);  chk("t2_pllrst_e28", pll_reset, 0);
    tick(20); chk("t2_retry_e48", retry_cnt, 2); chk("t2_state_e48", state_o, 0);
    tick(24); chk("t2_retry_e72", retry_cnt, 3);
    pll_lock = 1'b1;
    tick(4);  chk("t2_state_e76", state_o, 1);
    tick(1);  chk("t2_state_e77", state_o, 2);
    tick(7);  chk("t2_state_e84", state_o, 2);
    tick(1);  chk("t2_state_e85", state_o, 3); chk("t2_ready", ready, 1);
    chk("t2_retry_run", retry_cnt, 3);

    // 3. Glitch filtering in RUN
    pll_lock = 1'b0;
    tick(2);  pll_lock = 1'b1;
    tick(6);  chk("t3_glitch_state", state_o, 3); chk("t3_glitch_sysrst", sys_rst, 0);
    chk("t3_glitch_loss", loss_cnt, 0);
    pll_lock = 1'b0;
    tick(4);  chk("t3_loss_b4_state", state_o, 3); chk("t3_loss_b4_sysrst", sys_rst, 0);
    tick(1);  chk("t3_loss_state", state_o, 0); chk("t3_loss_sysrst", sys_rst, 1);
    chk("t3_loss_pllrst", pll_reset, 1); chk("t3_loss_cnt", loss_cnt, 1);
    chk("t3_loss_retry", retry_cnt, 3);
    pll_lock = 1'b1;
    tick(12); chk("t3_reseq_b17", state_o, 2);
    tick(1);  chk("t3_reseq_b18", state_o, 3);

    // 5a/5b/4. soft_rst in RUN, soft_rst in PLL_RST, STABLE interruption
    soft_rst = 1'b1;
    tick(1);  soft_rst = 1'b0;
    chk("t5_soft_state", state_o, 0); chk("t5_soft_pllrst", pll_reset, 1);
    chk("t5_soft_sysrst", sys_rst, 1); chk("t5_soft_ready", ready, 0);
    chk("t5_soft_retry", retry_cnt, 3); chk("t5_soft_loss", loss_cnt, 1);
    tick(1);  soft_rst = 1'b1;
    tick(1);  soft_rst = 1'b0; chk("t5_inrst_state", state_o, 0);
    tick(1);  chk("t5_inrst_pllrst_c4", pll_reset, 1);
    tick(1);  chk("t5_inrst_pllrst_c5", pll_reset, 0); chk("t5_state_c5", state_o, 1);
    tick(1);  chk("t4_state_c6", state_o, 2);
    tick(3);  pll_lock = 1'b0;
    tick(1);  pll_lock = 1'b1;
    tick(1);  chk("t4_state_c11", state_o, 2);
    tick(1);  chk("t4_state_c12", state_o, 1); chk("t4_retry", retry_cnt, 3);
    tick(1);  chk("t4_state_c13", state_o, 2);
    tick(7);  chk("t4_state_c20", state_o, 2); chk("t4_sysrst_c20", sys_rst, 1);
    tick(1);  chk("t4_state_c21", state_o, 3); chk("t4_sysrst_c21", sys_rst, 0);

    // 5c. soft_rst coinciding with a WAIT_LOCK timeout
    pll_lock = 1'b0; soft_rst = 1'b1;
    tick(1);  soft_rst = 1'b0;
    chk("t5c_state_d1", state_o, 0); chk("t5c_loss_d1", loss_cnt, 1);
    tick(23); chk("t5c_state_d24", state_o, 1);
    soft_rst = 1'b1;
    tick(1);  soft_rst = 1'b0;
    chk("t5c_state_d25", state_o, 0); chk("t5c_retry_d25", retry_cnt, 3);
    tick(24); chk("t5c_state_d49", state_o, 0); chk("t5c_retry_d49", retry_cnt, 4);

    // 6. Asynchronous reset in RUN, then retry saturation
    pll_lock = 1'b1;
    tick(12); chk("t6_state_pre", state_o, 2);
    tick(1);  chk("t6_state_run", state_o, 3);
    #2;
    reset = 1'b1; pll_lock = 1'b0;
    #1;
    chk("t6_async_sysrst", sys_rst, 1); chk("t6_async_pllrst", pll_reset, 1);
    chk("t6_async_ready", ready, 0); chk("t6_async_state", state_o, 0);
    chk("t6_async_retry", retry_cnt, 0); chk("t6_async_loss", loss_cnt, 0);
    reset = 1'b0;
    tick(24 * 254); chk("t6_retry_254", retry_cnt, 254);
    tick(24);       chk("t6_retry_255", retry_cnt, 255);
    tick(24 * 6);   chk("t6_retry_sat", retry_cnt, 255); chk("t6_sat_state", state_o, 0);

    // Lock arriving on the timeout cycle wins over the retry
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(21); pll_lock = 1'b1;
    tick(3);  chk("t7_lockwin_state", state_o, 2); chk("t7_lockwin_retry", retry_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
